if_fetch_stage: RTL and testbench

- Instruction-fetch stage sitting between the 64-bit PC register and the decode stage.
- Drives the PC's next-value input: hold, PC+4, or branch target.
- Issues requests to instruction memory over a req/ack handshake.
- Holds the IF/ID pipeline register (with a one-entry skid buffer) and handles decode back-pressure and branch flushes.

---
 rtl/if_fetch_stage_if.sv | 64 ++++++
 rtl/if_fetch_stage.sv | 168 ++++++++++++++++
 tb/tb_if_fetch_stage.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_stage_if.sv
// if_fetch_stage_if: signal bundle around the instruction-fetch stage.
//
// Groups everything the fetch stage exchanges with its neighbours:
//   pc / next_pc            - PC register output and its next-value input
//   imem_req/addr/ack/rdata - instruction-memory request/acknowledge handshake
//   branch_taken/target     - redirect from execute
//   id_ready                - decode back-pressure
//   ifid_valid/pc/instr     - IF/ID pipeline register contents
//
// Modports:
//   master - the fetch stage itself
//   slave  - the surroundings (PC register, memory, execute, decode)
interface if_fetch_stage_if #(
  parameter int unsigned ADDR_W  = 64,
  parameter int unsigned INSTR_W = 32
) ();

  logic [ADDR_W-1:0]  pc;
  logic [ADDR_W-1:0]  next_pc;

  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;

  logic               branch_taken;
  logic [ADDR_W-1:0]  branch_target;

  logic               id_ready;
  logic               ifid_valid;
  logic [ADDR_W-1:0]  ifid_pc;
  logic [INSTR_W-1:0] ifid_instr;

  modport master (
    input  pc,
    output next_pc,
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata,
    input  branch_taken,
    input  branch_target,
    input  id_ready,
    output ifid_valid,
    output ifid_pc,
    output ifid_instr
  );

  modport slave (
    output pc,
    input  next_pc,
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata,
    output branch_taken,
    output branch_target,
    output id_ready,
    input  ifid_valid,
    input  ifid_pc,
    input  ifid_instr
  );

endinterface

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: instruction-fetch stage between the PC register and decode.
//
// Computes the PC register's next value (hold, pc+4 or branch target), issues
// fetches over a req/ack handshake, and owns the IF/ID pipeline register plus
// a one-entry skid buffer that catches a response arriving while decode is
// stalled.
//
// Ports:
//   clock   - rising-edge clock, shared with the PC register
//   reset_n - asynchronous active-low reset
//   bus     - if_fetch_stage_if.master (PC, imem handshake, branch, IF/ID)
//
// States:
//   StFetch - request at pc; a response either lands in IF/ID or in the skid
//   StStall - skid full, waiting for decode; no request outstanding
//   StDrain - a branch orphaned an outstanding request; keep it alive at its
//             old address until acked, then drop the data
module if_fetch_stage #(
  parameter int unsigned       ADDR_W   = 64,
  parameter int unsigned       INSTR_W  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input logic            clock,
  input logic            reset_n,
  if_fetch_stage_if.master bus
);

  typedef enum logic [1:0] {
    StFetch,
    StStall,
    StDrain
  } state_e;

  state_e             state_q;

  logic               ifid_valid_q;
  logic [ADDR_W-1:0]  ifid_pc_q;
  logic [INSTR_W-1:0] ifid_instr_q;

  logic [ADDR_W-1:0]  skid_pc_q;
  logic [INSTR_W-1:0] skid_instr_q;

  logic [ADDR_W-1:0]  drain_addr_q;

  logic               accept;
  logic [ADDR_W-1:0]  pc_plus4;

  logic               req;
  logic [ADDR_W-1:0]  addr;
  logic [ADDR_W-1:0]  next_pc;

  // IF/ID can take a new instruction if it is empty or being consumed now.
  assign accept   = !ifid_valid_q || bus.id_ready;
  // Natural wrap at 2^ADDR_W.
  assign pc_plus4 = bus.pc + ADDR_W'(4);

  always_comb begin
    req     = 1'b0;
    addr    = bus.pc;
    next_pc = bus.pc;
    case (state_q)
      StFetch: begin
        req = 1'b1;
        if (bus.imem_ack) begin
          next_pc = pc_plus4;
        end
      end
      StStall: begin
        req = 1'b0;
      end
      StDrain: begin
        req  = 1'b1;
        addr = drain_addr_q;
      end
      default: begin
        req = 1'b0;
      end
    endcase
    if (bus.branch_taken) begin
      next_pc = bus.branch_target;
    end
    // The PC register has no reset of its own; it loads RESET_PC through us.
    if (!reset_n) begin
      next_pc = RESET_PC;
      req     = 1'b0;
    end
  end

  assign bus.next_pc    = next_pc;
  assign bus.imem_req   = req;
  assign bus.imem_addr  = addr;
  assign bus.ifid_valid = ifid_valid_q;
  assign bus.ifid_pc    = ifid_pc_q;
  assign bus.ifid_instr = ifid_instr_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StFetch;
      ifid_valid_q <= 1'b0;
      ifid_pc_q    <= '0;
      ifid_instr_q <= '0;
      skid_pc_q    <= '0;
      skid_instr_q <= '0;
      drain_addr_q <= '0;
    end else begin
      // Decode consumed the current entry; a load below may refill it.
      if (ifid_valid_q && bus.id_ready) begin
        ifid_valid_q <= 1'b0;
      end

      if (bus.branch_taken) begin
        ifid_valid_q <= 1'b0;
        case (state_q)
          StFetch: begin
            // An unacked request cannot be withdrawn; remember where it went.
            if (!bus.imem_ack) begin
              drain_addr_q <= bus.pc;
              state_q      <= StDrain;
            end
          end
          StStall: begin
            // Skid contents belong to the wrong path; just forget them.
            state_q <= StFetch;
          end
          StDrain: begin
            state_q <= StDrain;
          end
          default: begin
            state_q <= StFetch;
          end
        endcase
      end else begin
        case (state_q)
          StFetch: begin
            if (bus.imem_ack) begin
              if (accept) begin
                ifid_valid_q <= 1'b1;
                ifid_pc_q    <= bus.pc;
                ifid_instr_q <= bus.imem_rdata;
              end else begin
                skid_pc_q    <= bus.pc;
                skid_instr_q <= bus.imem_rdata;
                state_q      <= StStall;
              end
            end
          end
          StStall: begin
            if (bus.id_ready) begin
              ifid_valid_q <= 1'b1;
              ifid_pc_q    <= skid_pc_q;
              ifid_instr_q <= skid_instr_q;
              state_q      <= StFetch;
            end
          end
          StDrain: begin
            if (bus.imem_ack) begin
              state_q <= StFetch;
            end
          end
          default: begin
            state_q <= StFetch;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: models the PC register and a simple
// instruction memory whose data word is {16'hC0DE, addr[15:0]}.
module tb_if_fetch_stage;

  localparam int unsigned ADDR_W  = 64;
  localparam int unsigned INSTR_W = 32;

  logic clock;
  logic reset_n;

  logic auto_ack;
  logic man_ack;

  int total;
  int bad;

  if_fetch_stage_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) bus ();

  if_fetch_stage #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W),
    .RESET_PC(64'h0)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // PC register.
  always @(posedge clock) bus.pc <= bus.next_pc;

  // Memory: zero-wait when auto_ack, otherwise acks under man_ack.
  always_comb begin
    bus.imem_ack   = auto_ack ? bus.imem_req : (man_ack & bus.imem_req);
    bus.imem_rdata = {16'hC0DE, bus.imem_addr[15:0]};
  end

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    auto_ack = 1'b1;
    man_ack = 1'b0;
    bus.id_ready = 1'b1;
    bus.branch_taken = 1'b0;
    bus.branch_target = '0;
    step();
    step();
    #1;
    total++; if (bus.next_pc !== 64'h0) begin bad++;
      $display("FAIL reset_next_pc got=%h exp=%h", bus.next_pc, 64'h0); end
    total++; if (bus.imem_req !== 1'b0) begin bad++;
      $display("FAIL reset_req got=%b exp=0", bus.imem_req); end
    total++; if (bus.ifid_valid !== 1'b0) begin bad++;
      $display("FAIL reset_ifid_valid got=%b exp=0", bus.ifid_valid); end
    total++; if (bus.ifid_pc !== 64'h0) begin bad++;
      $display("FAIL reset_ifid_pc got=%h exp=0", bus.ifid_pc); end
    total++; if (bus.ifid_instr !== 32'h0) begin bad++;
      $display("FAIL reset_ifid_instr got=%h exp=0", bus.ifid_instr); end
    total++; if (bus.pc !== 64'h0) begin bad++;
      $display("FAIL reset_pc_loaded got=%h exp=0", bus.pc); end
  endtask

  task automatic test_stream();
    logic [63:0] exp_pc;
    logic [31:0] exp_instr;
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    total++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 64'h0) begin bad++;
      $display("FAIL stream_first_req got=%b/%h exp=1/0", bus.imem_req, bus.imem_addr); end
    total++; if (bus.next_pc !== 64'h4) begin bad++;
      $display("FAIL stream_first_next got=%h exp=4", bus.next_pc); end
    for (int i = 0; i < 4; i++) begin
      step();
      #1;
      exp_pc    = 64'(i * 4);
      exp_instr = 32'hC0DE_0000 | 32'(i * 4);
      total++; if (bus.ifid_valid !== 1'b1) begin bad++;
        $display("FAIL stream_valid[%0d] got=%b exp=1", i, bus.ifid_valid); end
      total++; if (bus.ifid_pc !== exp_pc) begin bad++;
        $display("FAIL stream_pc[%0d] got=%h exp=%h", i, bus.ifid_pc, exp_pc); end
      total++; if (bus.ifid_instr !== exp_instr) begin bad++;
        $display("FAIL stream_instr[%0d] got=%h exp=%h", i, bus.ifid_instr, exp_instr); end
    end
  endtask

  task automatic test_wait_ack();
    auto_ack = 1'b0;
    man_ack = 1'b0;
    #1;
    total++; if (bus.pc !== 64'h10) begin bad++;
      $display("FAIL wait_start_pc got=%h exp=10", bus.pc); end
    for (int c = 0; c < 3; c++) begin
      total++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 64'h10) begin bad++;
        $display("FAIL wait_req[%0d] got=%b/%h exp=1/10", c, bus.imem_req, bus.imem_addr); end
      total++; if (bus.next_pc !== 64'h10) begin bad++;
        $display("FAIL wait_hold[%0d] got=%h exp=10", c, bus.next_pc); end
      step();
      #1;
    end
    total++; if (bus.ifid_valid !== 1'b0) begin bad++;
      $display("FAIL wait_ifid_drained got=%b exp=0", bus.ifid_valid); end
    man_ack = 1'b1;
    #1;
    total++; if (bus.next_pc !== 64'h14) begin bad++;
      $display("FAIL wait_ack_next got=%h exp=14", bus.next_pc); end
    step();
    man_ack = 1'b0;
    #1;
    total++; if (bus.ifid_valid !== 1'b1 || bus.ifid_pc !== 64'h10) begin bad++;
      $display("FAIL wait_ifid got=%b/%h exp=1/10", bus.ifid_valid, bus.ifid_pc); end
    total++; if (bus.ifid_instr !== 32'hC0DE_0010) begin bad++;
      $display("FAIL wait_instr got=%h exp=c0de0010", bus.ifid_instr); end
  endtask

  task automatic test_stall();
    auto_ack = 1'b1;
    step();
    step();
    step();
    bus.id_ready = 1'b0;
    #1;
    total++; if (bus.pc !== 64'h20 || bus.next_pc !== 64'h24) begin bad++;
      $display("FAIL stall_entry got=%h/%h exp=20/24", bus.pc, bus.next_pc); end
    step();
    #1;
    total++; if (bus.imem_req !== 1'b0) begin bad++;
      $display("FAIL stall_req got=%b exp=0", bus.imem_req); end
    total++; if (bus.next_pc !== 64'h24) begin bad++;
      $display("FAIL stall_hold got=%h exp=24", bus.next_pc); end
    total++; if (bus.ifid_valid !== 1'b1 || bus.ifid_pc !== 64'h1C) begin bad++;
      $display("FAIL stall_ifid_kept got=%b/%h exp=1/1c", bus.ifid_valid, bus.ifid_pc); end
    step();
    #1;
    total++; if (bus.ifid_pc !== 64'h1C || bus.imem_req !== 1'b0) begin bad++;
      $display("FAIL stall_second got=%h/%b exp=1c/0", bus.ifid_pc, bus.imem_req); end
    bus.id_ready = 1'b1;
    #1;
    total++; if (bus.next_pc !== 64'h24) begin bad++;
      $display("FAIL stall_release_next got=%h exp=24", bus.next_pc); end
    step();
    #1;
    total++; if (bus.ifid_pc !== 64'h20 || bus.ifid_instr !== 32'hC0DE_0020) begin bad++;
      $display("FAIL stall_skid_out got=%h/%h exp=20/c0de0020", bus.ifid_pc, bus.ifid_instr); end
    total++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 64'h24) begin bad++;
      $display("FAIL stall_back_fetch got=%b/%h exp=1/24", bus.imem_req, bus.imem_addr); end
  endtask

  task automatic test_branch_drain();
    bus.branch_taken = 1'b1;
    bus.branch_target = 64'h40;
    #1;
    total++; if (bus.next_pc !== 64'h40) begin bad++;
      $display("FAIL br_ack_next got=%h exp=40", bus.next_pc); end
    step();
    bus.branch_taken = 1'b0;
    auto_ack = 1'b0;
    man_ack = 1'b0;
    #1;
    total++; if (bus.ifid_valid !== 1'b0) begin bad++;
      $display("FAIL br_ack_discard got=%b exp=0", bus.ifid_valid); end
    total++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 64'h40) begin bad++;
      $display("FAIL br_fetch40 got=%b/%h exp=1/40", bus.imem_req, bus.imem_addr); end
    step();
    bus.branch_taken = 1'b1;
    bus.branch_target = 64'h100;
    #1;
    total++; if (bus.next_pc !== 64'h100) begin bad++;
      $display("FAIL br_wait_next got=%h exp=100", bus.next_pc); end
    step();
    bus.branch_taken = 1'b0;
    #1;
    total++; if (bus.pc !== 64'h100 || bus.next_pc !== 64'h100) begin bad++;
      $display("FAIL drain_pc got=%h/%h exp=100/100", bus.pc, bus.next_pc); end
    total++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 64'h40) begin bad++;
      $display("FAIL drain_addr got=%b/%h exp=1/40", bus.imem_req, bus.imem_addr); end
    step();
    #1;
    total++; if (bus.imem_addr !== 64'h40) begin bad++;
      $display("FAIL drain_addr_hold got=%h exp=40", bus.imem_addr); end
    man_ack = 1'b1;
    #1;
    total++; if (bus.next_pc !== 64'h100) begin bad++;
      $display("FAIL drain_ack_next got=%h exp=100", bus.next_pc); end
    step();
    man_ack = 1'b0;
    #1;
    total++; if (bus.ifid_valid !== 1'b0) begin bad++;
      $display("FAIL drain_dropped got=%b exp=0", bus.ifid_valid); end
    total++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 64'h100) begin bad++;
      $display("FAIL drain_refetch got=%b/%h exp=1/100", bus.imem_req, bus.imem_addr); end
  endtask

  task automatic test_branch_redirects();
    bus.branch_taken = 1'b1;
    bus.branch_target = 64'h180;
    step();
    bus.branch_taken = 1'b0;
    #1;
    total++; if (bus.imem_addr !== 64'h100) begin bad++;
      $display("FAIL redir_drain got=%h exp=100", bus.imem_addr); end
    bus.branch_taken = 1'b1;
    bus.branch_target = 64'h200;
    #1;
    total++; if (bus.next_pc !== 64'h200) begin bad++;
      $display("FAIL redir_newer got=%h exp=200", bus.next_pc); end
    step();
    bus.branch_taken = 1'b0;
    #1;
    total++; if (bus.pc !== 64'h200 || bus.imem_addr !== 64'h100) begin bad++;
      $display("FAIL redir_drain_keep got=%h/%h exp=200/100", bus.pc, bus.imem_addr); end
    man_ack = 1'b1;
    step();
    man_ack = 1'b0;
    #1;
    total++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 64'h200) begin bad++;
      $display("FAIL redir_final got=%b/%h exp=1/200", bus.imem_req, bus.imem_addr); end
    total++; if (bus.ifid_valid !== 1'b0) begin bad++;
      $display("FAIL redir_no_data got=%b exp=0", bus.ifid_valid); end
    // Fill IF/ID then the skid, then branch out of the stall.
    bus.id_ready = 1'b0;
    auto_ack = 1'b1;
    step();
    step();
    #1;
    total++; if (bus.imem_req !== 1'b0 || bus.ifid_pc !== 64'h200) begin bad++;
      $display("FAIL stall2_enter got=%b/%h exp=0/200", bus.imem_req, bus.ifid_pc); end
    bus.branch_taken = 1'b1;
    bus.branch_target = 64'h300;
    bus.id_ready = 1'b1;
    #1;
    total++; if (bus.next_pc !== 64'h300) begin bad++;
      $display("FAIL stall2_br_next got=%h exp=300", bus.next_pc); end
    step();
    bus.branch_taken = 1'b0;
    #1;
    total++; if (bus.ifid_valid !== 1'b0) begin bad++;
      $display("FAIL stall2_skid_flushed got=%b exp=0", bus.ifid_valid); end
    total++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 64'h300) begin bad++;
      $display("FAIL stall2_refetch got=%b/%h exp=1/300", bus.imem_req, bus.imem_addr); end
    step();
    #1;
    total++; if (bus.ifid_valid !== 1'b1 || bus.ifid_pc !== 64'h300) begin bad++;
      $display("FAIL stall2_next_instr got=%b/%h exp=1/300", bus.ifid_valid, bus.ifid_pc); end
  endtask

  task automatic test_wrap();
    bus.branch_taken = 1'b1;
    bus.branch_target = 64'hFFFF_FFFF_FFFF_FFF8;
    step();
    bus.branch_taken = 1'b0;
    #1;
    total++; if (bus.next_pc !== 64'hFFFF_FFFF_FFFF_FFFC) begin bad++;
      $display("FAIL wrap_pre got=%h exp=fffffffffffffffc", bus.next_pc); end
    step();
    #1;
    total++; if (bus.next_pc !== 64'h0) begin bad++;
      $display("FAIL wrap_next got=%h exp=0", bus.next_pc); end
    total++; if (bus.imem_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin bad++;
      $display("FAIL wrap_addr got=%h exp=fffffffffffffffc", bus.imem_addr); end
    step();
    #1;
    total++; if (bus.pc !== 64'h0 || bus.ifid_pc !== 64'hFFFF_FFFF_FFFF_FFFC) begin bad++;
      $display("FAIL wrap_ifid got=%h/%h exp=0/fffffffffffffffc", bus.pc, bus.ifid_pc); end
  endtask

  task automatic test_reset_mid();
    auto_ack = 1'b0;
    man_ack = 1'b0;
    #1;
    reset_n = 1'b0;
    #1;
    total++; if (bus.imem_req !== 1'b0 || bus.ifid_valid !== 1'b0) begin bad++;
      $display("FAIL rmid_req_valid got=%b/%b exp=0/0", bus.imem_req, bus.ifid_valid); end
    total++; if (bus.ifid_pc !== 64'h0 || bus.ifid_instr !== 32'h0) begin bad++;
      $display("FAIL rmid_ifid got=%h/%h exp=0/0", bus.ifid_pc, bus.ifid_instr); end
    total++; if (bus.next_pc !== 64'h0) begin bad++;
      $display("FAIL rmid_next got=%h exp=0", bus.next_pc); end
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    total++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 64'h0) begin bad++;
      $display("FAIL rmid_no_drain got=%b/%h exp=1/0", bus.imem_req, bus.imem_addr); end
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_stream();
    test_wait_ack();
    test_stall();
    test_branch_drain();
    test_branch_redirects();
    test_wrap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
